main_fsm: RTL
=============

MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: op  input  2  instruction class from the instruction register; 00 data-processing, 01 memory, 10 branch, 11 illegal.
REQ-004 SHALL have port: funct  input  6  instruction funct; funct[5] = immediate operand (I), funct[0] = S bit (data-processing) or L bit (memory).
REQ-005 SHALL have port: mem_ready  input  1  memory completes the current access this cycle.
REQ-006 SHALL have port: mem_req  output  1  memory access request.
REQ-007 SHALL have port: mem_w  output  1  memory write enable.
REQ-008 SHALL have port: adr_src  output  1  address select; 0 = PC, 1 = ALU result.
REQ-009 SHALL have port: ir_write  output  1  instruction register load.
REQ-010 SHALL have port: next_pc  output  1  PC load.
REQ-011 SHALL have port: reg_w  output  1  register file write.
REQ-012 SHALL have port: branch  output  1  branch PC update.
REQ-013 SHALL have port: alu_op  output  1  to ALU decoder; 1 = decode cmd, 0 = force ADD.
REQ-014 SHALL have port: alu_src_a  output  2  00 = register A, 01 = PC.
REQ-015 SHALL have port: alu_src_b  output  2  00 = register B, 01 = extended immediate, 10 = constant 4.
REQ-016 SHALL have port: result_src  output  2  00 = ALU out register, 01 = read data, 10 = ALU result direct.
REQ-017 SHALL have port: illegal  output  1  high while in the trap state.
REQ-018 SHALL have port: state  output  4  current state encoding, for debug.

Function
REQ-019 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, UNKNOWN.
REQ-020 FETCH SHALL hold while mem_ready = 0 and go to DECODE on mem_ready = 1.
REQ-021 DECODE SHALL go to: EXECUTER if op = 00 and funct[5] = 0; EXECUTEI if op = 00 and funct[5] = 1; MEMADR if op = 01; BRANCH if op = 10; UNKNOWN if op = 11.
REQ-022 MEMADR SHALL go to MEMREAD if funct[0] = 1, else to MEMWRITE.
REQ-023 MEMREAD SHALL hold until mem_ready = 1, then go to MEMWB; MEMWB SHALL go to FETCH.
REQ-024 MEMWRITE SHALL hold until mem_ready = 1, then go to FETCH.
REQ-025 EXECUTER and EXECUTEI SHALL go to ALUWB; ALUWB and BRANCH SHALL go to FETCH.
REQ-026 UNKNOWN SHALL be absorbing until reset, with illegal = 1 and all strobes 0.
REQ-027 Per-state outputs SHALL be as follows; every output not listed is 0:
- FETCH: mem_req = 1; alu_src_a = 01; alu_src_b = 10; result_src = 10; ir_write = mem_ready; next_pc = mem_ready.
- DECODE: alu_src_a = 01; alu_src_b = 10; result_src = 10.
- MEMADR: alu_src_b = 01.
- MEMREAD: mem_req = 1; adr_src = 1.
- MEMWB: result_src = 01; reg_w = 1.
- MEMWRITE: mem_req = 1; mem_w = 1; adr_src = 1.
- EXECUTER: alu_op = 1.
- EXECUTEI: alu_op = 1; alu_src_b = 01.
- ALUWB: reg_w = 1.
- BRANCH: alu_src_b = 01; result_src = 10; branch = 1.
REQ-028 ir_write and next_pc SHALL pulse exactly one cycle per fetched instruction.
REQ-029 Instruction latency with mem_ready held at 1 SHALL be: data-processing 4 cycles; LDR 5; STR 4; B 3.
REQ-030 Unused state encodings SHALL transition to FETCH.

Reset
REQ-031 reset_n = 0 SHALL force the state to FETCH immediately, regardless of clk.
REQ-032 While reset_n = 0, mem_req, mem_w, ir_write, next_pc, reg_w, branch, alu_op and illegal SHALL be 0, and the mux selects SHALL take their FETCH values.
REQ-033 Reset asserted mid-instruction SHALL abandon it; no strobe SHALL be asserted after reset asserts.

Structure
REQ-034 The state enum and the mux-select constants (alu_src_a/b, result_src, adr_src) SHALL live in the shared CPU package.
REQ-035 The state-to-control table SHALL be one combinational sub-module, main_fsm_out; alu_op SHALL feed the existing ALU decoder.

Verification
REQ-036 ADD register (op = 00, funct = 001000), mem_ready = 1 -> FETCH, DECODE, EXECUTER, ALUWB; reg_w = 1 only in cycle 4.
REQ-037 LDR (op = 01, funct = 011001), with mem_ready = 0 for 2 cycles in MEMREAD -> MEMREAD held for 3 cycles; MEMWB reg_w = 1 with result_src = 01; total 7 cycles.
REQ-038 STR (op = 01, funct = 011000) -> mem_w = 1 and adr_src = 1 only in MEMWRITE; no reg_w.
REQ-039 B (op = 10) -> 3 cycles; branch = 1 once; FETCH with mem_ready = 0 for 4 cycles gives no ir_write or next_pc.
REQ-040 op = 11 -> UNKNOWN with illegal = 1 held for 10 cycles; reset_n pulse -> FETCH with illegal = 0.
REQ-041 reset_n asserted asynchronously in MEMWRITE -> mem_w = 0 before the next clk edge; state = FETCH.

Source files
------------

// File: rtl/main_fsm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : main_fsm_pkg
//  Description : Shared CPU control definitions. Holds the main controller
//                state enum, mux-select constants, opcode classes and the
//                control-word struct driven by the state table.
//  Revision    : 1.0 - initial release
// ============================================================================
package main_fsm_pkg;

    // Controller states; the 4-bit encoding is exported for debug.
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        UNKNOWN  = 4'd10
    } state_t;

    // Instruction classes carried in op
    localparam logic [1:0] c_OP_DP  = 2'b00;
    localparam logic [1:0] c_OP_MEM = 2'b01;
    localparam logic [1:0] c_OP_BR  = 2'b10;
    localparam logic [1:0] c_OP_ILL = 2'b11;

    // funct bit positions: immediate flag and S/L flag
    localparam int c_FUNCT_I  = 5;
    localparam int c_FUNCT_SL = 0;

    // ALU operand A select
    localparam logic [1:0] c_ALU_A_REG = 2'b00;
    localparam logic [1:0] c_ALU_A_PC  = 2'b01;

    // ALU operand B select
    localparam logic [1:0] c_ALU_B_REG  = 2'b00;
    localparam logic [1:0] c_ALU_B_IMM  = 2'b01;
    localparam logic [1:0] c_ALU_B_FOUR = 2'b10;

    // Result select
    localparam logic [1:0] c_RES_ALUOUT = 2'b00;
    localparam logic [1:0] c_RES_RDATA  = 2'b01;
    localparam logic [1:0] c_RES_ALU    = 2'b10;

    // Memory address select
    localparam logic c_ADR_PC  = 1'b0;
    localparam logic c_ADR_ALU = 1'b1;

    // One control word as produced by the state table
    typedef struct packed {
        logic       mem_req;
        logic       mem_w;
        logic       adr_src;
        logic       ir_write;
        logic       next_pc;
        logic       reg_w;
        logic       branch;
        logic       alu_op;
        logic       illegal;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
    } ctrl_t;

    // Control word while reset is held: strobes quiet, muxes parked on FETCH
    localparam ctrl_t c_CTRL_RESET = '{
        mem_req    : 1'b0,
        mem_w      : 1'b0,
        adr_src    : c_ADR_PC,
        ir_write   : 1'b0,
        next_pc    : 1'b0,
        reg_w      : 1'b0,
        branch     : 1'b0,
        alu_op     : 1'b0,
        illegal    : 1'b0,
        alu_src_a  : c_ALU_A_PC,
        alu_src_b  : c_ALU_B_FOUR,
        result_src : c_RES_ALU
    };

endpackage
`default_nettype wire

// File: rtl/main_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module      : main_fsm_if
//  Description : Control bus between the main controller and the datapath /
//                memory side. slave = controller, master = datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
interface main_fsm_if;

    logic [1:0] op;
    logic [5:0] funct;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_w;
    logic       adr_src;
    logic       ir_write;
    logic       next_pc;
    logic       reg_w;
    logic       branch;
    logic       alu_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       illegal;
    logic [3:0] state;

    modport slave (
        input  op, funct, mem_ready,
        output mem_req, mem_w, adr_src, ir_write, next_pc, reg_w, branch,
               alu_op, alu_src_a, alu_src_b, result_src, illegal, state
    );

    modport master (
        output op, funct, mem_ready,
        input  mem_req, mem_w, adr_src, ir_write, next_pc, reg_w, branch,
               alu_op, alu_src_a, alu_src_b, result_src, illegal, state
    );

endinterface
`default_nettype wire

// File: rtl/main_fsm_out.sv
`default_nettype none
// ============================================================================
//  Module      : main_fsm_out
//  Description : Combinational state-to-control table of the main controller.
//                Moore outputs, except ir_write/next_pc in FETCH which follow
//                mem_ready so the IR and PC load once per completed fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
module main_fsm_out
    import main_fsm_pkg::*;
(
    input  state_t i_state,
    input  logic   i_mem_ready,
    output ctrl_t  o_ctrl
);

    // Decode the current state into the control word; unlisted fields stay 0
    always_comb begin
        o_ctrl = '0;
        case (i_state)
            FETCH: begin
                o_ctrl.mem_req    = 1'b1;
                o_ctrl.alu_src_a  = c_ALU_A_PC;
                o_ctrl.alu_src_b  = c_ALU_B_FOUR;
                o_ctrl.result_src = c_RES_ALU;
                o_ctrl.ir_write   = i_mem_ready;
                o_ctrl.next_pc    = i_mem_ready;
            end
            DECODE: begin
                o_ctrl.alu_src_a  = c_ALU_A_PC;
                o_ctrl.alu_src_b  = c_ALU_B_FOUR;
                o_ctrl.result_src = c_RES_ALU;
            end
            MEMADR: begin
                o_ctrl.alu_src_b  = c_ALU_B_IMM;
            end
            MEMREAD: begin
                o_ctrl.mem_req    = 1'b1;
                o_ctrl.adr_src    = c_ADR_ALU;
            end
            MEMWB: begin
                o_ctrl.result_src = c_RES_RDATA;
                o_ctrl.reg_w      = 1'b1;
            end
            MEMWRITE: begin
                o_ctrl.mem_req    = 1'b1;
                o_ctrl.mem_w      = 1'b1;
                o_ctrl.adr_src    = c_ADR_ALU;
            end
            EXECUTER: begin
                o_ctrl.alu_op     = 1'b1;
            end
            EXECUTEI: begin
                o_ctrl.alu_op     = 1'b1;
                o_ctrl.alu_src_b  = c_ALU_B_IMM;
            end
            ALUWB: begin
                o_ctrl.reg_w      = 1'b1;
            end
            BRANCH: begin
                o_ctrl.alu_src_b  = c_ALU_B_IMM;
                o_ctrl.result_src = c_RES_ALU;
                o_ctrl.branch     = 1'b1;
            end
            UNKNOWN: begin
                o_ctrl.illegal    = 1'b1;
            end
            default: begin
                o_ctrl = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/main_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : main_fsm
//  Description : Multicycle CPU main controller. Walks each instruction
//                through fetch, decode and class-specific execute states,
//                traps on illegal opcodes until reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module main_fsm
    import main_fsm_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    main_fsm_if.slave   bus
);

    state_t r_state;
    state_t w_state_nxt;
    ctrl_t  w_tbl;
    ctrl_t  w_ctrl;
    logic   w_unused_funct;

    // Only the I and S/L bits of funct steer the controller
    assign w_unused_funct = ^bus.funct[4:1];

    // State register; reset drops straight back to FETCH without a clock
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state selection from the current state, opcode class and memory handshake
    always_comb begin
        w_state_nxt = FETCH;
        case (r_state)
            FETCH:    w_state_nxt = bus.mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (bus.op)
                    c_OP_DP:  w_state_nxt = bus.funct[c_FUNCT_I] ? EXECUTEI : EXECUTER;
                    c_OP_MEM: w_state_nxt = MEMADR;
                    c_OP_BR:  w_state_nxt = BRANCH;
                    default:  w_state_nxt = UNKNOWN;
                endcase
            end
            MEMADR:   w_state_nxt = bus.funct[c_FUNCT_SL] ? MEMREAD : MEMWRITE;
            MEMREAD:  w_state_nxt = bus.mem_ready ? MEMWB : MEMREAD;
            MEMWB:    w_state_nxt = FETCH;
            MEMWRITE: w_state_nxt = bus.mem_ready ? FETCH : MEMWRITE;
            EXECUTER: w_state_nxt = ALUWB;
            EXECUTEI: w_state_nxt = ALUWB;
            ALUWB:    w_state_nxt = FETCH;
            BRANCH:   w_state_nxt = FETCH;
            UNKNOWN:  w_state_nxt = UNKNOWN;
            default:  w_state_nxt = FETCH;
        endcase
    end

    main_fsm_out u_out (
        .i_state     (r_state),
        .i_mem_ready (bus.mem_ready),
        .o_ctrl      (w_tbl)
    );

    // Hold every strobe low while reset is asserted, even though FETCH would request memory
    always_comb begin
        w_ctrl = w_tbl;
        if (!reset_n) begin
            w_ctrl = c_CTRL_RESET;
        end
    end

    assign bus.mem_req    = w_ctrl.mem_req;
    assign bus.mem_w      = w_ctrl.mem_w;
    assign bus.adr_src    = w_ctrl.adr_src;
    assign bus.ir_write   = w_ctrl.ir_write;
    assign bus.next_pc    = w_ctrl.next_pc;
    assign bus.reg_w      = w_ctrl.reg_w;
    assign bus.branch     = w_ctrl.branch;
    assign bus.alu_op     = w_ctrl.alu_op;
    assign bus.alu_src_a  = w_ctrl.alu_src_a;
    assign bus.alu_src_b  = w_ctrl.alu_src_b;
    assign bus.result_src = w_ctrl.result_src;
    assign bus.illegal    = w_ctrl.illegal;
    assign bus.state      = r_state;

endmodule
`default_nettype wire
